// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_pkg
// Description : Shared encodings for the writeback stage: result-source
//               selects, load func3 codes and the stage state type.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage : wb_stage_pkg
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/halfword lane of a little-endian
//               read word and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Halfword lane ignores addr[0]; misaligned halves fold onto their pair.
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_func3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Writeback stage: registers ALU/PC+4 results directly, waits
//               for data-memory responses on loads, drives the register-file
//               write port and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             valid_wb_i,
    output logic             ready_wb_o,
    input  logic             RegWrite_wb_i,
    input  logic [4:0]       Rd_wb_i,
    input  logic [2:0]       func3_wb_i,
    input  logic [1:0]       wb_sel_wb_i,
    input  logic [31:0]      alu_result_wb_i,
    input  logic [31:0]      pc_plus4_wb_i,

    input  logic             dmem_rvalid_i,
    input  logic [31:0]      dmem_rdata_i,

    output logic             RegWrite_wb_o,
    output logic [4:0]       Rd_wb_o,
    output logic [31:0]      Wr_reg_data_wb_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    wb_state_t        r_state;
    logic             r_ld_regwrite;
    logic [4:0]       r_ld_rd;
    logic [2:0]       r_ld_func3;
    logic [1:0]       r_ld_addr;

    logic             r_regwrite;
    logic [4:0]       r_rd;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_instret;

    logic             w_transfer;
    logic             w_is_load;
    logic [31:0]      w_direct_data;
    logic [31:0]      w_ld_data;

    assign ready_wb_o    = (r_state == WB_IDLE);
    assign w_transfer    = valid_wb_i && ready_wb_o;
    assign w_is_load     = (wb_sel_wb_i == WB_SEL_LOAD);
    // Reserved select 11 falls back to the ALU result.
    assign w_direct_data = (wb_sel_wb_i == WB_SEL_PC4) ? pc_plus4_wb_i : alu_result_wb_i;

    load_align u_load_align (
        .i_rdata (dmem_rdata_i),
        .i_addr  (r_ld_addr),
        .i_func3 (r_ld_func3),
        .o_data  (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= WB_IDLE;
            r_ld_regwrite <= 1'b0;
            r_ld_rd       <= 5'd0;
            r_ld_func3    <= 3'd0;
            r_ld_addr     <= 2'd0;
            r_regwrite    <= 1'b0;
            r_rd          <= 5'd0;
            r_wdata       <= 32'd0;
            r_instret     <= {CNT_W{1'b0}};
        end else if (r_state == WB_IDLE) begin
            r_regwrite <= 1'b0;
            if (w_transfer) begin
                if (w_is_load) begin
                    r_ld_regwrite <= RegWrite_wb_i;
                    r_ld_rd       <= Rd_wb_i;
                    r_ld_func3    <= func3_wb_i;
                    r_ld_addr     <= alu_result_wb_i[1:0];
                    r_state       <= WB_WAIT_LOAD;
                end else begin
                    r_regwrite <= RegWrite_wb_i && (Rd_wb_i != 5'd0);
                    r_rd       <= Rd_wb_i;
                    r_wdata    <= w_direct_data;
                    r_instret  <= r_instret + c_one;
                end
            end
        end else begin
            r_regwrite <= 1'b0;
            // Response latency is unbounded; the stage simply stalls upstream.
            if (dmem_rvalid_i) begin
                r_regwrite <= r_ld_regwrite && (r_ld_rd != 5'd0);
                r_rd       <= r_ld_rd;
                r_wdata    <= w_ld_data;
                r_instret  <= r_instret + c_one;
                r_state    <= WB_IDLE;
            end
        end
    end

    assign RegWrite_wb_o    = r_regwrite;
    assign Rd_wb_o          = r_rd;
    assign Wr_reg_data_wb_o = r_wdata;
    assign instret_o        = r_instret;

endmodule : wb_stage
`default_nettype wire
